// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit buffer: drain FSM encoding, the
// port_id constants the address decoder uses for the TX ports, and a status helper.
package uart_tx_fifo_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_BUSY = 2'd2
   } tx_state_e;

   localparam logic [7:0] TX_DATA_PORT = 8'h10;
   localparam logic [7:0] TX_CTRL_PORT = 8'h11;
   localparam logic [7:0] TX_STAT_PORT = 8'h12;

   localparam int STAT_COUNT_W = 5;

   // Status byte as read back through in_port; assembled by the read mux, not the FIFO.
   function automatic logic [7:0] tx_status_byte(
      input logic                    ovf,
      input logic                    is_full,
      input logic                    is_empty,
      input logic [STAT_COUNT_W-1:0] cnt
   );
      return {ovf, is_full, is_empty, cnt};
   endfunction

endpackage

// File: rtl/uart_tx_fifo_ram_dp.sv
// Register-array storage for the TX FIFO: one synchronous write port and one
// asynchronous read port, so a pop can capture the head entry on the same edge.
module fifo_ram_dp #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit-side FIFO between the PicoBlaze TX data port and the UART transmit
// engine; a three-state drain FSM hands bytes over with a load/ready handshake.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] din,
   input  logic              clr_ovf,
   input  logic              tx_rdy,
   output logic              tx_load,
   output logic [DATA_W-1:0] tx_data,
   output logic              empty,
   output logic              full,
   output logic [DEPTH_LOG2:0] count,
   output logic              overflow
);

   localparam int CNT_W = DEPTH_LOG2 + 1;
   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  empty_q, empty_d;
   logic                  full_q, full_d;
   logic                  overflow_q, overflow_d;

   tx_state_e             state_q;
   logic                  tx_load_q;
   logic [DATA_W-1:0]     tx_data_q;

   logic                  pop;
   logic                  push;
   logic                  drop;
   logic [DATA_W-1:0]     rd_data;

   fifo_ram_dp #(
      .DATA_W (DATA_W),
      .ADDR_W (DEPTH_LOG2)
   ) u_ram (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr_q),
      .wr_data (din),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );

   // A pop frees the slot it reads, so a full FIFO still accepts a same-cycle push.
   always_comb begin
      pop  = (state_q == S_IDLE) && !empty_q && tx_rdy;
      push = wr_en && (!full_q || pop);
      drop = wr_en && full_q && !pop;

      wr_ptr_d = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      empty_d = (count_d == '0);
      full_d  = (count_d == FULL_COUNT);

      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
      end
   end

   // BUSY only releases once the transmitter has dropped tx_rdy, so a byte is
   // never loaded into a transmitter that has not yet taken the previous one.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         tx_load_q <= 1'b0;
         tx_data_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               tx_load_q <= 1'b0;
               if (pop) begin
                  tx_data_q <= rd_data;
                  tx_load_q <= 1'b1;
                  state_q   <= S_LOAD;
               end
            end
            S_LOAD: begin
               tx_load_q <= 1'b0;
               state_q   <= S_BUSY;
            end
            S_BUSY: begin
               tx_load_q <= 1'b0;
               if (!tx_rdy) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               tx_load_q <= 1'b0;
               state_q   <= S_IDLE;
            end
         endcase
      end
   end

   assign tx_load  = tx_load_q;
   assign tx_data  = tx_data_q;
   assign empty    = empty_q;
   assign full     = full_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus a randomized
// run scored against a queue-based model of the buffer and a simple transmitter.
module tb_uart_tx_fifo;

   localparam int DATA_W     = 8;
   localparam int DEPTH_LOG2 = 4;
   localparam int DEPTH      = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              wr_en;
   logic [DATA_W-1:0] din;
   logic              clr_ovf;
   logic              tx_rdy;
   logic              tx_load;
   logic [DATA_W-1:0] tx_data;
   logic              empty;
   logic              full;
   logic [DEPTH_LOG2:0] count;
   logic              overflow;

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] got_q[$];

   uart_tx_fifo #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .din      (din),
      .clr_ovf  (clr_ovf),
      .tx_rdy   (tx_rdy),
      .tx_load  (tx_load),
      .tx_data  (tx_data),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transmitter that drops tx_rdy for 'busy' cycles after each load it sees.
   task automatic collect(input int n, input int busy_init);
      int guard = 0;
      int busy = busy_init;
      got_q.delete();
      while (got_q.size() < n && guard < 400) begin
         tx_rdy = (busy == 0);
         if (busy > 0) busy--;
         tick();
         guard++;
         if (tx_load) begin
            got_q.push_back(tx_data);
            busy = 2;
         end
      end
   endtask

   task automatic test_reset();
      int loads = 0;
      reset = 1'b1; wr_en = 1'b0; din = '0; clr_ovf = 1'b0; tx_rdy = 1'b1;
      tick(); tick();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", overflow); end
      checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL reset_load: got %0b expected 0", tx_load); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 00", tx_data); end
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (tx_load === 1'b1) loads++;
      end
      checks++; if (loads !== 0) begin errors++; $display("FAIL idle_no_load: got %0d loads expected 0", loads); end
      checks++; if (empty !== 1'b1 || count !== 5'd0) begin
         errors++; $display("FAIL idle_empty: got empty=%0b count=%0d expected 1/0", empty, count);
      end
      $display("test_reset done");
   endtask

   task automatic test_single();
      int loads = 0;
      int guard = 0;
      tx_rdy = 1'b1; wr_en = 1'b1; din = 8'h41;
      tick();
      wr_en = 1'b0;
      checks++; if (tx_load !== 1'b0 || count !== 5'd1) begin
         errors++; $display("FAIL single_push: got load=%0b count=%0d expected 0/1", tx_load, count);
      end
      tick();
      checks++; if (tx_load !== 1'b1) begin errors++; $display("FAIL single_load: got %0b expected 1", tx_load); end
      checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL single_data: got %0h expected 41", tx_data); end
      checks++; if (count !== 5'd0 || empty !== 1'b1) begin
         errors++; $display("FAIL single_count: got count=%0d empty=%0b expected 0/1", count, empty);
      end
      tick();
      checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL single_pulse: got %0b expected 0", tx_load); end
      // tx_rdy still high: the FSM must stay parked and keep buffering
      wr_en = 1'b1; din = 8'h55;
      tick();
      wr_en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (tx_load === 1'b1) loads++;
      end
      checks++; if (loads !== 0 || count !== 5'd1) begin
         errors++; $display("FAIL busy_park: got loads=%0d count=%0d expected 0/1", loads, count);
      end
      tx_rdy = 1'b0;
      tick();
      tx_rdy = 1'b1;
      while (tx_load !== 1'b1 && guard < 20) begin tick(); guard++; end
      checks++; if (tx_load !== 1'b1 || tx_data !== 8'h55) begin
         errors++; $display("FAIL busy_release: got load=%0b data=%0h expected 1/55", tx_load, tx_data);
      end
      tx_rdy = 1'b0;
      tick(); tick(); tick();
      $display("test_single done");
   endtask

   task automatic test_fill_overflow();
      tx_rdy = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         wr_en = 1'b1; din = 8'(i);
         tick();
      end
      checks++; if (full !== 1'b1 || count !== 5'd16) begin
         errors++; $display("FAIL fill: got full=%0b count=%0d expected 1/16", full, count);
      end
      din = 8'hAA;
      tick();
      wr_en = 1'b0;
      checks++; if (overflow !== 1'b1 || count !== 5'd16) begin
         errors++; $display("FAIL drop: got ovf=%0b count=%0d expected 1/16", overflow, count);
      end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %0b expected 0", overflow); end
      $display("test_fill_overflow done");
   endtask

   task automatic test_wrap_simul();
      logic [DATA_W-1:0] exp;
      tx_rdy = 1'b1; wr_en = 1'b1; din = 8'hBB;
      tick();
      wr_en = 1'b0;
      checks++; if (tx_load !== 1'b1 || tx_data !== 8'h00) begin
         errors++; $display("FAIL simul_pop: got load=%0b data=%0h expected 1/00", tx_load, tx_data);
      end
      checks++; if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin
         errors++; $display("FAIL simul_count: got count=%0d ovf=%0b full=%0b expected 16/0/1", count, overflow, full);
      end
      collect(16, 2);
      checks++; if (got_q.size() !== 16) begin
         errors++; $display("FAIL drain_len: got %0d expected 16", got_q.size());
      end
      for (int i = 0; i < got_q.size(); i++) begin
         exp = (i == 15) ? 8'hBB : 8'(i + 1);
         checks++; if (got_q[i] !== exp) begin
            errors++; $display("FAIL drain_order[%0d]: got %0h expected %0h", i, got_q[i], exp);
         end
      end
      tx_rdy = 1'b0;
      tick(); tick(); tick();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0b expected 1", empty); end
      $display("test_wrap_simul done");
   endtask

   task automatic test_ovf_precedence();
      tx_rdy = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         wr_en = 1'b1; din = 8'($urandom);
         tick();
      end
      clr_ovf = 1'b1; din = 8'hCC;
      tick();
      wr_en = 1'b0; clr_ovf = 1'b0;
      checks++; if (overflow !== 1'b1 || count !== 5'd16) begin
         errors++; $display("FAIL ovf_precedence: got ovf=%0b count=%0d expected 1/16", overflow, count);
      end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear2: got %0b expected 0", overflow); end
      $display("test_ovf_precedence done");
   endtask

   task automatic test_reset_abort();
      int loads = 0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
         errors++; $display("FAIL reset_discard: got count=%0d empty=%0b full=%0b expected 0/1/0", count, empty, full);
      end
      // reset lands on the edge that would have popped
      tx_rdy = 1'b1; wr_en = 1'b1; din = 8'h77;
      tick();
      wr_en = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (tx_load !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
         errors++; $display("FAIL abort_pop: got load=%0b count=%0d empty=%0b expected 0/0/1", tx_load, count, empty);
      end
      for (int i = 0; i < 5; i++) begin tick(); if (tx_load === 1'b1) loads++; end
      // reset during the load cycle itself
      wr_en = 1'b1; din = 8'h78;
      tick();
      wr_en = 1'b0;
      tick();
      checks++; if (tx_load !== 1'b1 || tx_data !== 8'h78) begin
         errors++; $display("FAIL abort_setup: got load=%0b data=%0h expected 1/78", tx_load, tx_data);
      end
      wr_en = 1'b1; din = 8'h79; reset = 1'b1;
      tick();
      wr_en = 1'b0; reset = 1'b0;
      checks++; if (tx_load !== 1'b0 || count !== 5'd0 || empty !== 1'b1 || tx_data !== 8'h00) begin
         errors++; $display("FAIL abort_load: got load=%0b count=%0d empty=%0b data=%0h expected 0/0/1/00",
                            tx_load, count, empty, tx_data);
      end
      for (int i = 0; i < 5; i++) begin tick(); if (tx_load === 1'b1) loads++; end
      checks++; if (loads !== 0) begin errors++; $display("FAIL abort_quiet: got %0d loads expected 0", loads); end
      $display("test_reset_abort done");
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] q[$];
      logic              ovf_m = 1'b0;
      logic              seen_low = 1'b1;
      int                linger = 0;
      int                busy = 0;
      int                guard = 0;
      int                loads = 0;
      logic              p_wr, p_clr, p_rdy, drop, load;
      logic [DATA_W-1:0] p_din;
      int                size_before;
      reset = 1'b1; wr_en = 1'b0; clr_ovf = 1'b0; tx_rdy = 1'b1;
      tick();
      reset = 1'b0;
      for (int cyc = 0; cyc < 2600; cyc++) begin
         if (cyc < 2000) begin
            wr_en   = ($urandom_range(0, 99) < ((cyc / 250) % 2 == 0 ? 70 : 20));
            din     = 8'($urandom);
            clr_ovf = ($urandom_range(0, 99) < 5);
         end else begin
            wr_en = 1'b0; clr_ovf = 1'b0;
         end
         if (linger > 0) begin tx_rdy = 1'b1; linger--; end
         else if (busy > 0) begin tx_rdy = 1'b0; busy--; end
         else tx_rdy = ($urandom_range(0, 99) < 90);
         p_wr = wr_en; p_din = din; p_clr = clr_ovf; p_rdy = tx_rdy;
         tick();
         load = tx_load;
         size_before = q.size();
         if (load === 1'b1) begin
            loads++;
            checks++; if (p_rdy !== 1'b1 || !seen_low || size_before == 0) begin
               errors++; $display("FAIL rnd_load_legal cyc %0d: got rdy=%0b seen_low=%0b depth=%0d expected 1/1/>0",
                                  cyc, p_rdy, seen_low, size_before);
            end
            if (size_before > 0) begin
               checks++; if (tx_data !== q[0]) begin
                  errors++; $display("FAIL rnd_data cyc %0d: got %0h expected %0h", cyc, tx_data, q[0]);
               end
               void'(q.pop_front());
            end
            seen_low = 1'b0;
            linger = $urandom_range(0, 2);
            busy = $urandom_range(2, 6);
         end else if (p_rdy == 1'b0) begin
            seen_low = 1'b1;
         end
         drop = 1'b0;
         if (p_wr) begin
            if (size_before < DEPTH || load === 1'b1) q.push_back(p_din);
            else drop = 1'b1;
         end
         if (drop) ovf_m = 1'b1;
         else if (p_clr) ovf_m = 1'b0;
         checks++; if (count !== 5'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
            errors++; $display("FAIL rnd_level cyc %0d: got count=%0d empty=%0b full=%0b expected count=%0d",
                               cyc, count, empty, full, q.size());
         end
         checks++; if (overflow !== ovf_m) begin
            errors++; $display("FAIL rnd_ovf cyc %0d: got %0b expected %0b", cyc, overflow, ovf_m);
         end
         if (cyc >= 2000 && q.size() == 0) guard++;
      end
      checks++; if (q.size() !== 0 || loads < 50) begin
         errors++; $display("FAIL rnd_drain: got %0d left, %0d loads expected 0 left, >=50 loads", q.size(), loads);
      end
      $display("test_random done: %0d loads, %0d idle-empty cycles", loads, guard);
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; din = '0; clr_ovf = 1'b0; tx_rdy = 1'b1;
      test_reset();
      test_single();
      test_fill_overflow();
      test_wrap_simul();
      test_ovf_precedence();
      test_reset_abort();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
